// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/subtract pipeline:
// operand classification record, flag bit positions, rounding mode and
// the canonical quiet-NaN pattern generator.
package fp_pkg;

   // Classification of one operand after the effective sign has been applied
   typedef struct packed {
      logic sign;
      logic is_inf;
      logic is_nan;
      logic is_snan;
   } fp_class_t;

   // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}
   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   // Only round-to-nearest-even is implemented
   localparam logic [1:0] RND_RNE    = 2'd0;
   localparam logic [1:0] ROUND_MODE = RND_RNE;

   // Canonical quiet NaN: sign 0, exponent all ones, top mantissa bit set, rest zero
   function automatic logic [63:0] qnan_gen(input int exp_w, input int man_w);
      logic [63:0] q;
      q = '0;
      for (int i = 0; i < 64; i++) begin
         if (i >= man_w - 1 && i < man_w + exp_w) begin
            q[i] = 1'b1;
         end
      end
      return q;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
   parameter int WIDTH = 27,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] in_vec,
   output logic [CNT_W-1:0] count
);

   logic found;

   // Scan from the MSB and latch the position of the first set bit
   always_comb begin
      count = CNT_W'(WIDTH);
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found && in_vec[i]) begin
            count = CNT_W'(WIDTH - 1 - i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754-style adder/subtractor with valid/ready handshake.
// S1 unpacks, orders by magnitude and aligns; S2 adds and normalises;
// S3 rounds to nearest-even, packs and applies special-case results.
module fp_addsub_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic                   op,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [3:0]             flags
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int X    = MAN_W + 1;
   localparam int N    = X + 3;
   localparam int WIDE = 2 * X + 2;
   localparam int EW1  = EXP_W + 1;
   localparam int LZW  = $clog2(N + 1);
   localparam int SH_W = (LZW > EW1) ? LZW : EW1;
   localparam logic [W-1:0]     QNAN     = W'(qnan_gen(EXP_W, MAN_W));
   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   function automatic fp_class_t classify(input logic [W-1:0] x, input logic sign);
      fp_class_t c;
      logic      ones;
      ones      = &x[W-2 -: EXP_W];
      c.sign    = sign;
      c.is_inf  = ones && (x[MAN_W-1:0] == '0);
      c.is_nan  = ones && (x[MAN_W-1:0] != '0);
      c.is_snan = c.is_nan && !x[MAN_W-1];
      return c;
   endfunction

   logic enable;

   fp_class_t        a_cls, b_cls;
   logic             swap, sign_l, sign_s;
   logic [W-2:0]     mag_l, mag_s;
   logic [EXP_W-1:0] exp_l, exp_s, shift;
   logic [X-1:0]     man_l, man_s;
   logic [WIDE-1:0]  wide;

   logic             s1_valid_d, s1_valid_q, s1_sign_d, s1_sign_q, s1_sub_d, s1_sub_q;
   logic [EXP_W-1:0] s1_exp_d, s1_exp_q;
   logic [N-1:0]     s1_man_l_d, s1_man_l_q, s1_man_s_d, s1_man_s_q;
   logic             s1_spec_d, s1_spec_q, s1_spec_inv_d, s1_spec_inv_q;
   logic [W-1:0]     s1_spec_res_d, s1_spec_res_q;

   logic [N:0]       sum;
   logic [LZW-1:0]   lz;
   logic [SH_W-1:0]  lz_ext, lim, sh;

   logic             s2_valid_d, s2_valid_q, s2_sign_d, s2_sign_q;
   logic [EW1-1:0]   s2_exp_d, s2_exp_q;
   logic [N-1:0]     s2_man_d, s2_man_q;
   logic             s2_spec_d, s2_spec_q, s2_spec_inv_d, s2_spec_inv_q;
   logic [W-1:0]     s2_spec_res_d, s2_spec_res_q;

   logic [X-1:0]     m, mant;
   logic [X:0]       mr;
   logic             g, st, rup, inexact;
   logic [EW1-1:0]   e;

   logic             out_valid_d, out_valid_q;
   logic [W-1:0]     result_d, result_q;
   logic [3:0]       flags_d, flags_q;

   assign enable    = !out_valid_q || out_ready;
   assign in_ready  = enable;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;

   // S1: classify operands, put the larger magnitude first and align the smaller one
   always_comb begin
      a_cls  = classify(a, a[W-1]);
      b_cls  = classify(b, b[W-1] ^ op);
      swap   = b[W-2:0] > a[W-2:0];
      mag_l  = swap ? b[W-2:0] : a[W-2:0];
      mag_s  = swap ? a[W-2:0] : b[W-2:0];
      sign_l = swap ? b_cls.sign : a_cls.sign;
      sign_s = swap ? a_cls.sign : b_cls.sign;
      exp_l  = (mag_l[W-2 -: EXP_W] == '0) ? EXP_W'(1) : mag_l[W-2 -: EXP_W];
      exp_s  = (mag_s[W-2 -: EXP_W] == '0) ? EXP_W'(1) : mag_s[W-2 -: EXP_W];
      man_l  = {|mag_l[W-2 -: EXP_W], mag_l[MAN_W-1:0]};
      man_s  = {|mag_s[W-2 -: EXP_W], mag_s[MAN_W-1:0]};
      shift  = exp_l - exp_s;
      wide   = {man_s, {(X + 2){1'b0}}} >> shift;

      s1_valid_d = in_valid;
      s1_sign_d  = sign_l;
      s1_sub_d   = sign_l ^ sign_s;
      s1_exp_d   = exp_l;
      s1_man_l_d = {man_l, 3'b000};
      if (int'(shift) >= X + 2) begin
         s1_man_s_d = {{(N - 1){1'b0}}, |man_s};
      end else begin
         s1_man_s_d = {wide[WIDE-1 -: X+2], |wide[X-1:0]};
      end

      s1_spec_d     = a_cls.is_nan | b_cls.is_nan | a_cls.is_inf | b_cls.is_inf;
      s1_spec_inv_d = a_cls.is_snan | b_cls.is_snan
                    | (a_cls.is_inf & b_cls.is_inf & (a_cls.sign != b_cls.sign));
      if (a_cls.is_nan || b_cls.is_nan || s1_spec_inv_d) begin
         s1_spec_res_d = QNAN;
      end else if (a_cls.is_inf) begin
         s1_spec_res_d = {a_cls.sign, EXP_ONES, {MAN_W{1'b0}}};
      end else begin
         s1_spec_res_d = {b_cls.sign, EXP_ONES, {MAN_W{1'b0}}};
      end
   end

   fp_lzc #(.WIDTH(N), .CNT_W(LZW)) u_lzc (
      .in_vec (sum[N-1:0]),
      .count  (lz)
   );

   // S2: add or subtract magnitudes, then normalise without dropping below exponent 1
   always_comb begin
      if (s1_sub_q) begin
         sum = {1'b0, s1_man_l_q} - {1'b0, s1_man_s_q};
      end else begin
         sum = {1'b0, s1_man_l_q} + {1'b0, s1_man_s_q};
      end
      lz_ext = SH_W'(lz);
      lim    = SH_W'(s1_exp_q - EXP_W'(1));
      sh     = (lz_ext > lim) ? lim : lz_ext;
      if (sum[N]) begin
         s2_man_d = {sum[N:2], sum[1] | sum[0]};
         s2_exp_d = {1'b0, s1_exp_q} + EW1'(1);
      end else begin
         s2_man_d = sum[N-1:0] << sh;
         s2_exp_d = {1'b0, s1_exp_q} - EW1'(sh);
      end
      s2_valid_d    = s1_valid_q;
      s2_sign_d     = s1_sign_q & ~(s1_sub_q & (sum == '0));
      s2_spec_d     = s1_spec_q;
      s2_spec_inv_d = s1_spec_inv_q;
      s2_spec_res_d = s1_spec_res_q;
   end

   // S3: round to nearest-even, detect overflow and pack the final word and flags
   always_comb begin
      m   = s2_man_q[N-1:3];
      g   = s2_man_q[2];
      st  = |s2_man_q[1:0];
      rup = (ROUND_MODE == RND_RNE) ? (g & (st | m[0])) : 1'b0;
      mr  = {1'b0, m} + {{X{1'b0}}, rup};
      if (mr[X]) begin
         mant = mr[X:1];
         e    = s2_exp_q + EW1'(1);
      end else begin
         mant = mr[X-1:0];
         e    = s2_exp_q;
      end
      inexact     = g | st;
      out_valid_d = s2_valid_q;
      result_d    = '0;
      flags_d     = '0;
      if (!s2_valid_q) begin
         result_d = '0;
      end else if (s2_spec_q) begin
         result_d               = s2_spec_res_q;
         flags_d[FLAG_INVALID]  = s2_spec_inv_q;
      end else if (e >= {1'b0, EXP_ONES}) begin
         result_d               = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
         flags_d[FLAG_OVERFLOW] = 1'b1;
         flags_d[FLAG_INEXACT]  = 1'b1;
      end else begin
         result_d = {s2_sign_q, (mant[X-1] ? e[EXP_W-1:0] : {EXP_W{1'b0}}), mant[MAN_W-1:0]};
         flags_d[FLAG_UNDERFLOW] = ~mant[X-1] & inexact;
         flags_d[FLAG_INEXACT]   = inexact;
      end
   end

   // All stages advance together whenever the output register can take a new value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q    <= 1'b0;
         s1_sign_q     <= 1'b0;
         s1_sub_q      <= 1'b0;
         s1_exp_q      <= '0;
         s1_man_l_q    <= '0;
         s1_man_s_q    <= '0;
         s1_spec_q     <= 1'b0;
         s1_spec_inv_q <= 1'b0;
         s1_spec_res_q <= '0;
         s2_valid_q    <= 1'b0;
         s2_sign_q     <= 1'b0;
         s2_exp_q      <= '0;
         s2_man_q      <= '0;
         s2_spec_q     <= 1'b0;
         s2_spec_inv_q <= 1'b0;
         s2_spec_res_q <= '0;
         out_valid_q   <= 1'b0;
         result_q      <= '0;
         flags_q       <= '0;
      end else if (enable) begin
         s1_valid_q    <= s1_valid_d;
         s1_sign_q     <= s1_sign_d;
         s1_sub_q      <= s1_sub_d;
         s1_exp_q      <= s1_exp_d;
         s1_man_l_q    <= s1_man_l_d;
         s1_man_s_q    <= s1_man_s_d;
         s1_spec_q     <= s1_spec_d;
         s1_spec_inv_q <= s1_spec_inv_d;
         s1_spec_res_q <= s1_spec_res_d;
         s2_valid_q    <= s2_valid_d;
         s2_sign_q     <= s2_sign_d;
         s2_exp_q      <= s2_exp_d;
         s2_man_q      <= s2_man_d;
         s2_spec_q     <= s2_spec_d;
         s2_spec_inv_q <= s2_spec_inv_d;
         s2_spec_res_q <= s2_spec_res_d;
         out_valid_q   <= out_valid_d;
         result_q      <= result_d;
         flags_q       <= flags_d;
      end
   end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: the driver pushes hand-computed
// expectations as operands are accepted, the monitor pops and compares
// every result the block hands downstream.
module tb_fp_addsub_pipe;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flg;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  flags;

   exp_t        exp_q[$];
   int          checks;
   int          errors;
   int          ready_mode;
   bit          held;
   logic [31:0] held_res;
   logic [3:0]  held_flg;

   fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Downstream ready: steady high, or toggling every cycle under back-pressure tests
   initial out_ready = 1'b1;
   always @(posedge clk) begin
      #1;
      if (ready_mode == 1) out_ready = ~out_ready;
      else                 out_ready = 1'b1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Drive one operand pair and record its expected result once the block accepts it
   task automatic applyStimulus(input string name, input logic [31:0] av, input logic [31:0] bv,
                                input logic opv, input logic [31:0] er, input logic [3:0] ef);
      bit acc;
      int n;
      exp_t x;
      a = av; b = bv; op = opv; in_valid = 1'b1;
      acc = 0; n = 0;
      while (!acc && n < 100) begin
         @(negedge clk);
         if (in_ready) begin
            x.res = er; x.flg = ef; x.name = name;
            exp_q.push_back(x);
            acc = 1;
         end
         n++;
         @(posedge clk);
         #1;
      end
      if (!acc) checkOutput({name, " accept timeout"}, 32'd1, 32'd0);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      checkOutput("drain pending", exp_q.size(), 32'd0);
   endtask

   // Monitor: compare each handed-off result and check outputs hold steady while stalled
   initial begin
      exp_t x;
      held = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 0;
         end else begin
            if (held) begin
               checkOutput("hold valid", {31'b0, out_valid}, 32'd1);
               checkOutput("hold result", result, held_res);
               checkOutput("hold flags", {28'b0, flags}, {28'b0, held_flg});
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected output", result, 32'hDEADBEEF);
               end else begin
                  x = exp_q.pop_front();
                  checkOutput({x.name, " result"}, result, x.res);
                  checkOutput({x.name, " flags"}, {28'b0, flags}, {28'b0, x.flg});
               end
            end
            held     = out_valid && !out_ready;
            held_res = result;
            held_flg = flags;
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d errors so far", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      checks = 0; errors = 0; ready_mode = 0;
      in_valid = 1'b0; a = '0; b = '0; op = 1'b0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset result", result, 32'd0);
      checkOutput("reset flags", {28'b0, flags}, 32'd0);
      checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] directed vectors");
      applyStimulus("6+8", 32'h40C00000, 32'h41000000, 1'b0, 32'h41600000, 4'h0);
      n = 1;
      while (!out_valid && n < 10) begin
         @(posedge clk); #1; n++;
      end
      checkOutput("latency 6+8", n, 32'd3);
      drain();

      applyStimulus("1+2^-24", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1);
      applyStimulus("tie odd", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1);
      applyStimulus("inf-inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8);
      applyStimulus("max+max", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5);
      applyStimulus("6-6", 32'h40C00000, 32'h40C00000, 1'b1, 32'h00000000, 4'h0);
      applyStimulus("subnormal", 32'h00800000, 32'h00400000, 1'b1, 32'h00400000, 4'h0);
      applyStimulus("-0+-0", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0);
      applyStimulus("-inf+1", 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'h0);
      applyStimulus("snan+1", 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8);
      applyStimulus("qnan+1", 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0);
      applyStimulus("1-1.5", 32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 4'h0);
      applyStimulus("2+3", 32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 4'h0);
      drain();

      $display("[TB] back-to-back with toggling out_ready");
      ready_mode = 1;
      applyStimulus("b2b 1+1", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0);
      applyStimulus("b2b 2+1", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'h0);
      applyStimulus("b2b 3+1", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'h0);
      applyStimulus("b2b 4+1", 32'h40800000, 32'h3F800000, 1'b0, 32'h40A00000, 4'h0);
      applyStimulus("b2b 5+1", 32'h40A00000, 32'h3F800000, 1'b0, 32'h40C00000, 4'h0);
      applyStimulus("b2b 6+1", 32'h40C00000, 32'h3F800000, 1'b0, 32'h40E00000, 4'h0);
      applyStimulus("b2b 7+1", 32'h40E00000, 32'h3F800000, 1'b0, 32'h41000000, 4'h0);
      applyStimulus("b2b 8+1", 32'h41000000, 32'h3F800000, 1'b0, 32'h41100000, 4'h0);
      drain();
      ready_mode = 0;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] reset with operations in flight");
      applyStimulus("flush a", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0);
      applyStimulus("flush b", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'h0);
      applyStimulus("flush c", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'h0);
      checkOutput("in-flight out_valid", {31'b0, out_valid}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("mid-reset out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("mid-reset result", result, 32'd0);
      checkOutput("mid-reset flags", {28'b0, flags}, 32'd0);
      checkOutput("mid-reset in_ready", {31'b0, in_ready}, 32'd1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("no stale output", {31'b0, out_valid}, 32'd0);
      end
      @(posedge clk); #1;
      applyStimulus("post-reset 2+3", 32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 4'h0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
